// File: rtl/gap_motion_7_if.sv
// Handshake/control bundle for the line-7 gap motion generator.
// master: frame, start, load, run, sw. slave: gap_x, direction, bounce, count.
interface gap_motion_7_if;
  logic        frame;
  logic        start_machine;
  logic        load_counter;
  logic        run;
  logic [6:2]  sw;
  logic [15:0] gap_x;
  logic        moving_right;
  logic        bounce;
  logic [7:0]  bounce_count;

  modport master (
    output frame, start_machine, load_counter, run, sw,
    input  gap_x, moving_right, bounce, bounce_count
  );

  modport slave (
    input  frame, start_machine, load_counter, run, sw,
    output gap_x, moving_right, bounce, bounce_count
  );
endinterface

// File: rtl/gap_motion_7.sv
// Ping-pong gap mover for the line-7 bar: steps gap_x once per frame strobe.
// Ports: clk, reset (sync, active-high), bus (slave side of gap_motion_7_if).
module gap_motion_7 #(
  parameter logic [15:0] START_X = 16'd250,
  parameter logic [15:0] L_LIMIT = 16'd26,
  parameter logic [15:0] R_EDGE  = 16'd622
) (
  input  logic          clk,
  input  logic          reset,
  gap_motion_7_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RIGHT = 2'd1,
    S_LEFT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_gap_x;
  logic [15:0] w_gap_nxt;
  logic        r_bounce;
  logic        w_bounce_nxt;
  logic [7:0]  r_cnt;
  logic [15:0] w_len;
  logic [15:0] w_step;
  logic [15:0] w_rmax;
  logic [15:0] w_sum;

  assign w_len  = {8'd0, bus.sw[6:4], 5'd0};
  assign w_step = {14'd0, bus.sw[3:2]} + 16'd1;
  assign w_rmax = R_EDGE - w_len;
  assign w_sum  = r_gap_x + w_step;

  // The >= test also catches a gap already past a bound that
  // shrank because the length grew mid-move.
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_x;
    w_bounce_nxt = 1'b0;
    if (bus.frame && bus.run) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_machine)
            w_state_nxt = S_RIGHT;
        end
        S_RIGHT: begin
          if (w_sum >= w_rmax) begin
            w_gap_nxt    = w_rmax;
            w_state_nxt  = S_LEFT;
            w_bounce_nxt = 1'b1;
          end else begin
            w_gap_nxt = w_sum;
          end
        end
        S_LEFT: begin
          if (r_gap_x < L_LIMIT + w_step) begin
            w_gap_nxt    = L_LIMIT;
            w_state_nxt  = S_RIGHT;
            w_bounce_nxt = 1'b1;
          end else begin
            w_gap_nxt = r_gap_x - w_step;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.load_counter) begin
      r_state  <= S_IDLE;
      r_gap_x  <= START_X;
      r_bounce <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_gap_x  <= w_gap_nxt;
      r_bounce <= w_bounce_nxt;
      // Count trails the pulse by one cycle.
      if (r_bounce && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.gap_x        = r_gap_x;
  assign bus.moving_right = (r_state != S_LEFT);
  assign bus.bounce       = r_bounce;
  assign bus.bounce_count = r_cnt;

endmodule

// File: tb/tb_gap_motion_7.sv
// Self-checking bench for gap_motion_7: directed scenarios plus random traffic.
// A behavioural model tracks position/direction/count and is compared each cycle.
module tb_gap_motion_7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gap_motion_7_if bus ();

  gap_motion_7 #(
    .START_X(16'd250),
    .L_LIMIT(16'd26),
    .R_EDGE (16'd622)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 0;

  // Model: 0 = waiting, 1 = heading right, 2 = heading left.
  int m_gx, m_dir, m_cnt, m_b;

  always @(posedge clk) begin
    int len, stp, rmax, nb;
    len  = int'(bus.sw[6:4]) * 32;
    stp  = int'(bus.sw[3:2]) + 1;
    rmax = 622 - len;
    nb   = 0;
    if (reset || bus.load_counter) begin
      m_gx = 250; m_dir = 0; m_cnt = 0; m_b = 0;
    end else begin
      if (bus.frame && bus.run) begin
        if (m_dir == 0) begin
          if (bus.start_machine) m_dir = 1;
        end else if (m_dir == 1) begin
          if (m_gx + stp >= rmax) begin
            m_gx = rmax; m_dir = 2; nb = 1;
          end else m_gx = m_gx + stp;
        end else begin
          if (m_gx < 26 + stp) begin
            m_gx = 26; m_dir = 1; nb = 1;
          end else m_gx = m_gx - stp;
        end
      end
      if (m_b == 1 && m_cnt < 255) m_cnt++;
      m_b = nb;
    end
  end

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gap_x", int'(bus.gap_x), m_gx);
      chk("model_moving_right", int'(bus.moving_right), (m_dir != 2) ? 1 : 0);
      chk("model_bounce", int'(bus.bounce), m_b);
      chk("model_bounce_count", int'(bus.bounce_count), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    bus.frame = 1'b1;
    tick();
    bus.frame = 1'b0;
  endtask

  task automatic load();
    bus.load_counter = 1'b1;
    tick();
    bus.load_counter = 1'b0;
  endtask

  initial begin
    int prev, g0, c0, mr0, saw_b, k;
    reset = 1'b1;
    bus.frame = 0; bus.start_machine = 0; bus.load_counter = 0;
    bus.run = 0; bus.sw = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1;

    chk("reset_gap_x", int'(bus.gap_x), 250);
    chk("reset_moving_right", int'(bus.moving_right), 1);
    chk("reset_bounce", int'(bus.bounce), 0);
    chk("reset_count", int'(bus.bounce_count), 0);

    bus.start_machine = 1; bus.run = 1;
    strobe();
    chk("start_first_gap", int'(bus.gap_x), 250);
    strobe();
    chk("start_second_gap", int'(bus.gap_x), 251);
    chk("start_moving_right", int'(bus.moving_right), 1);

    // Right bounce, length 0, step 4.
    load();
    bus.sw = 5'b00011;
    strobe();
    prev = 0;
    k = 0;
    while (!bus.bounce && k < 200) begin
      prev = int'(bus.gap_x);
      strobe();
      k++;
    end
    chk("rbounce_prev", prev, 618);
    chk("rbounce_gap", int'(bus.gap_x), 622);
    chk("rbounce_pulse", int'(bus.bounce), 1);
    chk("rbounce_dir", int'(bus.moving_right), 0);
    tick();
    chk("rbounce_pulse_end", int'(bus.bounce), 0);
    chk("rbounce_count", int'(bus.bounce_count), 1);

    // Length grows while moving right at 500.
    load();
    bus.sw = 5'b00001;
    strobe();
    repeat (125) strobe();
    chk("grow_pre_gap", int'(bus.gap_x), 500);
    bus.sw = 5'b11101;
    strobe();
    chk("grow_clamp_gap", int'(bus.gap_x), 398);
    chk("grow_clamp_dir", int'(bus.moving_right), 0);
    chk("grow_clamp_bounce", int'(bus.bounce), 1);
    strobe();
    chk("grow_step_down", int'(bus.gap_x), 396);

    // Left bounce with step 4.
    bus.sw = 5'b11111;
    k = 0;
    do begin
      strobe();
      k++;
    end while (!bus.bounce && k < 200);
    chk("lbounce_gap", int'(bus.gap_x), 26);
    chk("lbounce_dir", int'(bus.moving_right), 1);
    chk("lbounce_pulse", int'(bus.bounce), 1);
    tick();

    // Pause.
    g0 = int'(bus.gap_x);
    c0 = int'(bus.bounce_count);
    mr0 = int'(bus.moving_right);
    saw_b = 0;
    bus.run = 0;
    repeat (10) begin
      strobe();
      if (bus.bounce) saw_b = 1;
    end
    chk("pause_gap", int'(bus.gap_x), g0);
    chk("pause_count", int'(bus.bounce_count), c0);
    chk("pause_dir", int'(bus.moving_right), mr0);
    chk("pause_bounce", saw_b, 0);
    bus.run = 1;
    repeat (40) strobe();

    // Load coincident with frame.
    bus.frame = 1; bus.load_counter = 1;
    tick();
    bus.frame = 0; bus.load_counter = 0;
    chk("load_gap", int'(bus.gap_x), 250);
    chk("load_dir", int'(bus.moving_right), 1);
    chk("load_count", int'(bus.bounce_count), 0);
    bus.start_machine = 0;
    strobe();
    strobe();
    chk("idle_hold_gap", int'(bus.gap_x), 250);

    // Saturation: frame every cycle, ~306 bounces.
    bus.start_machine = 1;
    bus.sw = 5'b11111;
    bus.frame = 1;
    repeat (28500) tick();
    bus.frame = 0;
    tick();
    chk("sat_count", int'(bus.bounce_count), 255);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.load_counter = ($urandom_range(0, 149) == 0);
      bus.frame = ($urandom_range(0, 2) == 0);
      bus.run = ($urandom_range(0, 9) != 0);
      bus.start_machine = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) bus.sw = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 0; bus.frame = 0; bus.load_counter = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/gap_motion_7.md
# gap_motion_7

Upstream motion generator for the line-7 horizontal bar. It produces the registered x-position of the moving gap (`gap_x`), which the line renderer uses to split the bar into left and right segments. It replaces the separate frame-clocked direction machine and counter with a single-clock design: a ping-pong state machine advances the gap once per frame strobe, bounces it between bounds that track the switch-selected gap length, and counts bounces.

## Interface
Parameters:
- `START_X`, 250: gap position after reset or load.
- `L_LIMIT`, 26: minimum `gap_x`. Keeps the left segment, which ends at `gap_x-16`, at or beyond x=10.
- `R_EDGE`, 622: right bound for the gap's right edge. Maximum `gap_x` is `R_EDGE - length`.

Ports (single clock; reset is synchronous and active-high):
- `clk` in 1: system pixel clock.
- `reset` in 1: synchronous, active-high. Initialises all state.
- `frame` in 1: one-`clk`-wide strobe, once per video frame, synchronous to `clk`.
- `start_machine` in 1: level. Leaves IDLE on the next `frame` strobe.
- `load_counter` in 1: synchronous reload to `START_X` and IDLE.
- `run` in 1: motion enable. When 0, position and state are frozen (pause).
- `sw` in [6:2]:
  - `sw[6:4]` sets length = {`sw[6:4]`, 5'b0}, range 0..224.
  - `sw[3:2]` sets step = `sw[3:2]` + 1 pixels per frame.
- `gap_x` out 16: current gap left position.
- `moving_right` out 1: direction flag.
- `bounce` out 1: one-`clk` pulse on each reversal.
- `bounce_count` out 8: number of reversals, saturating.

## Operation
States:
- IDLE: waiting for start.
- RIGHT: gap moving toward higher x.
- LEFT: gap moving toward lower x.

Arithmetic:
- All arithmetic is 16-bit unsigned. length and step are zero-extended.
- `rmax = R_EDGE - length`, recomputed combinationally every cycle.

Update rule, evaluated in any cycle with `frame`=1 and `run`=1:
- IDLE:
  - If `start_machine`=1, go to RIGHT. `gap_x` is unchanged on this strobe.
  - Otherwise stay in IDLE.
- RIGHT:
  - If `gap_x + step >= rmax`: set `gap_x <= rmax`, go to LEFT, pulse `bounce`.
  - Otherwise: `gap_x <= gap_x + step`.
  - If `gap_x > rmax` already (length grew mid-move), the same clamp-and-reverse applies.
- LEFT:
  - If `gap_x < L_LIMIT + step`: set `gap_x <= L_LIMIT`, go to RIGHT, pulse `bounce`.
  - Otherwise: `gap_x <= gap_x - step`. This comparison cannot underflow.

Other rules:
- `frame`=1 with `run`=0: no change in any state, and `bounce` stays 0.
- `bounce_count` increments with each `bounce` pulse and saturates at 255.
- `moving_right` is 1 in IDLE and RIGHT, 0 in LEFT.
- Priority: `reset` > `load_counter` > frame update.
- Load: `gap_x`=`START_X`, state=IDLE, `bounce_count`=0, `bounce`=0.
- `start_machine` is only sampled on a `frame` strobe. Dropping it while in RIGHT or LEFT has no effect.

## Timing
Reset values:
- `gap_x` = `START_X` (250).
- State = IDLE.
- `moving_right` = 1.
- `bounce` = 0.
- `bounce_count` = 0.

Latency and pulse width:
- All outputs are registered. They change in the `clk` cycle after the cycle in which `frame` is sampled high, so latency is 1 `clk`.
- `bounce` is high for exactly one cycle. It coincides with the clamped `gap_x` value and the new direction.
- `bounce_count` reflects a bounce one cycle after the `bounce` pulse.

Concurrency and sensitivity:
- `load_counter` asserted in the same cycle as `frame` wins, and no step occurs.
- `sw` changes take effect at the next `frame` strobe. No other `sw` sensitivity exists.
- Reset asserted mid-move returns to reset values on the next edge, regardless of `frame`.

## Test plan
- **Reset and start:** reset, then `start_machine`=1, `run`=1, `sw`=5'b00000, two frame strobes → `gap_x`=250 after the first strobe (state RIGHT), 251 after the second. `moving_right`=1.
- **Right bounce, zero length:** `sw[3:2]`=3 (step 4), length 0, run to the bound → `gap_x` sequence ends 618, 622. `bounce` pulses one cycle. `moving_right`=0. `bounce_count`=1.
- **Length change while at bound:** `sw[6:4]`=3'b111 (length 224) while `gap_x`=500, moving right → next strobe gives `gap_x`=398 and LEFT. The next strobe steps down by `step`.
- **Left bounce:** LEFT with step 4 from `gap_x`=29 → next strobe gives `gap_x`=26, RIGHT, `bounce`=1.
- **Pause:** `run`=0 for 10 strobes → `gap_x`, state and `bounce_count` are unchanged. `bounce` stays 0.
- **Load and saturation:**
  - `load_counter`=1 coincident with `frame` at `gap_x`=400 → `gap_x`=250, IDLE, `bounce_count`=0.
  - Force 300 bounces (step 4, length 224) → `bounce_count` holds at 255.
